// File: rtl/reset_boot_sequencer.sv
// rtl/reset_boot_sequencer.sv - staged multi-domain reset release with re-trigger, event counter and clock-enable divider
module reset_boot_sequencer #(
    parameter int CYCLES      = 20,
    parameter int NUM_DOMAINS = 2,
    parameter int STAGE_GAP   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ext_reset_req,
    input  logic                   soft_reset_req,
    input  logic [DIV_WIDTH-1:0]   div_ratio,
    output logic                   clk_en,
    output logic [NUM_DOMAINS-1:0] reset_o,
    output logic                   all_released,
    output logic                   busy,
    output logic [7:0]             reset_count
);
    localparam int MAX_CNT = (CYCLES > STAGE_GAP) ? CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [1:0] {
        S_HOLD,
        S_STAGE,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic [7:0]             count_q, count_d;
    logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
    logic                   ext_prev_q, ext_prev_d;

    logic rst_ok;
    logic ext_lvl;
    logic retrig;
    logic count_inc;

    assign rst_ok    = rst_sync_q[SYNC_STAGES-1];
    assign ext_lvl   = ext_sync_q[SYNC_STAGES-1];
    assign retrig    = ext_lvl | soft_reset_req;
    assign count_inc = (ext_lvl & ~ext_prev_q) | soft_reset_req;

    // rst_ok is a flop cleared asynchronously, so the tick drops at once on reset_n
    assign clk_en       = rst_ok & (div_cnt_q >= div_ratio);
    assign reset_o      = rst_q;
    assign all_released = (state_q == S_RUN);
    assign busy         = (state_q != S_RUN);
    assign reset_count  = count_q;

    always_comb begin
        rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
        ext_sync_d = {ext_sync_q[SYNC_STAGES-2:0], ext_reset_req};
        div_cnt_d  = (!rst_ok || clk_en) ? '0 : div_cnt_q + DIV_WIDTH'(1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_d      = rst_q;
        count_d    = count_q;
        ext_prev_d = ext_lvl;
        if (!rst_ok) begin
            state_d    = S_HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            rst_d      = '1;
            count_d    = '0;
            ext_prev_d = 1'b0;
        end else begin
            if (count_inc && (count_q != 8'hFF)) begin
                count_d = count_q + 8'd1;
            end
            if (retrig) begin
                state_d = S_HOLD;
                cnt_d   = '0;
                idx_d   = '0;
                rst_d   = '1;
            end else begin
                case (state_q)
                    S_HOLD: begin
                        if (cnt_q == CNT_W'(CYCLES)) begin
                            rst_d[0] = 1'b0;
                            cnt_d    = CNT_W'(1);
                            idx_d    = IDX_W'(1);
                            state_d  = (NUM_DOMAINS == 1) ? S_RUN : S_STAGE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_STAGE: begin
                        // cnt restarts at 1 after each release so STAGE_GAP edges separate them
                        if (cnt_q == CNT_W'(STAGE_GAP)) begin
                            rst_d[idx_q] = 1'b0;
                            cnt_d        = CNT_W'(1);
                            if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                                state_d = S_RUN;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = S_RUN;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_q      <= '1;
            count_q    <= '0;
            div_cnt_q  <= '0;
            rst_sync_q <= '0;
            ext_sync_q <= '0;
            ext_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_q      <= rst_d;
            count_q    <= count_d;
            div_cnt_q  <= div_cnt_d;
            rst_sync_q <= rst_sync_d;
            ext_sync_q <= ext_sync_d;
            ext_prev_q <= ext_prev_d;
        end
    end
endmodule
